// File: rtl/seg7_scan_driver.sv
// Purpose : multiplexed N-digit 7-segment driver with frame-aligned shadow update,
//           hex/decimal decode, leading-zero blanking, decimal points and PWM dimming.
// Latency : an/seg/dp are registered, one cycle behind the scan index/prescaler.
// Backpressure: none; load is always accepted, the newest load wins at the next frame.
//
// Ports
//   clk         system clock
//   rst         synchronous reset, active-low
//   digits_in   4 bits per digit, digit 0 (units, rightmost) in [3:0]
//   dp_in       decimal point per digit, 1 = lit
//   load        capture digits_in/dp_in into the staging register
//   hex_mode    1: glyphs 0-F, 0: glyphs 0-9 with values above 9 shown as '-'
//   blank_lz    1: blank leading zeros (digit 0 is never blanked)
//   brightness  0 = dark, all-ones = always on, otherwise duty = brightness/2^BRIGHT_W
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point segment
//   an          digit enables, bit k drives digit k
//   frame_start one-cycle pulse in the first cycle of the digit 0 slot

module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_W     = 18,
    parameter int BRIGHT_W   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      hex_mode,
    input  logic                      blank_lz,
    input  logic [BRIGHT_W-1:0]       brightness,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_start
);

    localparam int               IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic             POL_LOW  = (ACTIVE_LOW != 0);

    // Levels the pins sit at when nothing is driven.
    localparam logic [6:0]            SEG_IDLE = POL_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_IDLE  = POL_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_IDLE  = POL_LOW ? '1 : '0;

    // Glyphs below are written in active-low form and flipped at the output.
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SCAN_W-1:0]       presc;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] stage_dig;
    logic [NUM_DIGITS-1:0]   stage_dp;
    logic [4*NUM_DIGITS-1:0] disp_dig;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic                    pending;

    // ------------------------------------------------------------------
    // Combinational next-output path
    // ------------------------------------------------------------------
    logic                    presc_wrap;
    logic                    boundary;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    upper_zero;
    logic [3:0]              cur_val;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [BRIGHT_W-1:0]     phase;
    logic                    slot_en;
    logic [6:0]              seg_al;
    logic                    dp_lit;
    logic [NUM_DIGITS-1:0]   an_act;
    logic [6:0]              seg_nxt;
    logic                    dp_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    function automatic logic [6:0] decode_al(input logic [3:0] v, input logic hex);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        // Decimal mode has no glyph for A-F; show a dash so bad BCD is visible.
        if (!hex && (v > 4'd9)) begin
            g = GLYPH_DASH;
        end
        return g;
    endfunction

    assign presc_wrap = &presc;
    assign boundary   = presc_wrap && (idx == LAST_IDX);

    always_comb begin
        // Leading-zero mask: walk down from the top digit while everything seen is zero.
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            upper_zero  = upper_zero && (disp_dig[4*k +: 4] == 4'd0);
            lz_blank[k] = blank_lz && upper_zero;
        end

        // Select the digit currently being scanned.
        cur_val   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_val   = disp_dig[4*k +: 4];
                cur_dp    = disp_dp[k];
                cur_blank = lz_blank[k];
            end
        end

        // PWM phase is the top of the prescaler, so each slot gets 2^BRIGHT_W
        // equal sub-periods; all-ones brightness bypasses the compare for 100% duty.
        phase   = presc[SCAN_W-1 -: BRIGHT_W];
        slot_en = (&brightness) || (phase < brightness);

        seg_al = GLYPH_BLANK;
        dp_lit = 1'b0;
        an_act = '0;
        if (slot_en) begin
            seg_al = cur_blank ? GLYPH_BLANK : decode_al(cur_val, hex_mode);
            dp_lit = cur_dp;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                an_act[k] = (idx == IDX_W'(k));
            end
        end

        seg_nxt = POL_LOW ? seg_al  : ~seg_al;
        dp_nxt  = POL_LOW ? ~dp_lit : dp_lit;
        an_nxt  = POL_LOW ? ~an_act : an_act;
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc       <= '0;
            idx         <= '0;
            stage_dig   <= '0;
            stage_dp    <= '0;
            disp_dig    <= '0;
            disp_dp     <= '0;
            pending     <= 1'b0;
            seg         <= SEG_IDLE;
            dp          <= DP_IDLE;
            an          <= AN_IDLE;
            frame_start <= 1'b0;
        end else begin
            presc <= presc + SCAN_W'(1);
            if (presc_wrap) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
            end

            // Registered off the boundary so it lines up with idx returning to 0.
            frame_start <= boundary;

            if (load) begin
                stage_dig <= digits_in;
                stage_dp  <= dp_in;
            end

            // Display only changes on the frame boundary. A load landing exactly on
            // the boundary goes straight through rather than waiting a whole frame.
            if (boundary && load) begin
                disp_dig <= digits_in;
                disp_dp  <= dp_in;
                pending  <= 1'b0;
            end else if (boundary && pending) begin
                disp_dig <= stage_dig;
                disp_dp  <= stage_dp;
                pending  <= 1'b0;
            end else if (load) begin
                pending  <= 1'b1;
            end

            seg <= seg_nxt;
            dp  <= dp_nxt;
            an  <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a 4-digit, 16-cycle-slot configuration.
// Each task starts and ends on the sample where frame_start is high.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int SW = 4;
    localparam int BW = 2;

    // Active-low glyphs written out by hand.
    localparam logic [6:0] S0    = 7'b1000000;
    localparam logic [6:0] S1    = 7'b1111001;
    localparam logic [6:0] S2    = 7'b0100100;
    localparam logic [6:0] S3    = 7'b0110000;
    localparam logic [6:0] S4    = 7'b0011001;
    localparam logic [6:0] S5    = 7'b0010010;
    localparam logic [6:0] S6    = 7'b0000010;
    localparam logic [6:0] S7    = 7'b1111000;
    localparam logic [6:0] S8    = 7'b0000000;
    localparam logic [6:0] SA    = 7'b0001000;
    localparam logic [6:0] SB    = 7'b0000011;
    localparam logic [6:0] SC    = 7'b1000110;
    localparam logic [6:0] SD    = 7'b0100001;
    localparam logic [6:0] SDASH = 7'b0111111;
    localparam logic [6:0] SBLK  = 7'b1111111;

    logic          clk = 1'b0;
    logic          rst;
    logic [4*ND-1:0] digits_in;
    logic [ND-1:0] dp_in;
    logic          load;
    logic          hex_mode;
    logic          blank_lz;
    logic [BW-1:0] brightness;
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] an;
    logic          frame_start;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(ND), .SCAN_W(SW), .BRIGHT_W(BW), .ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .load(load),
        .hex_mode(hex_mode), .blank_lz(blank_lz), .brightness(brightness),
        .seg(seg), .dp(dp), .an(an), .frame_start(frame_start)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until frame_start is seen; a missing pulse counts as a failure.
    task automatic wait_frame();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 200);
        if (frame_start !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL wait_frame: frame_start not seen within 200 cycles");
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    task automatic test_reset();
        int first;
        rst = 1'b0; load = 1'b0; hex_mode = 1'b0; blank_lz = 1'b0;
        digits_in = '0; dp_in = '0; brightness = 2'd3;
        repeat (3) tick();
        total++; if (an !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b exp=1111", an); end
        total++; if (seg !== SBLK) begin bad++; $display("FAIL reset_seg got=%b exp=%b", seg, SBLK); end
        total++; if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", dp); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
        rst = 1'b1;
        tick();
        total++; if (an !== 4'b1110) begin bad++; $display("FAIL release_an got=%b exp=1110", an); end
        total++; if (seg !== S0) begin bad++; $display("FAIL release_seg got=%b exp=%b", seg, S0); end
        first = 0;
        for (int n = 2; n <= 100 && first == 0; n++) begin
            tick();
            if (frame_start === 1'b1) first = n;
        end
        total++; if (first != 64) begin bad++; $display("FAIL first_frame_start got=%0d exp=64", first); end
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        int slot;
        exp_seg[0] = S4; exp_seg[1] = S3; exp_seg[2] = S2; exp_seg[3] = S1;
        do_load(16'h1234, 4'b0000);
        wait_frame();
        for (int t = 1; t <= 64; t++) begin
            tick();
            slot   = (t - 1) / 16;
            exp_an = ~(4'b0001 << slot);
            total++; if (an !== exp_an) begin bad++; $display("FAIL scan_an t=%0d got=%b exp=%b", t, an, exp_an); end
            total++; if (seg !== exp_seg[slot]) begin bad++; $display("FAIL scan_seg t=%0d got=%b exp=%b", t, seg, exp_seg[slot]); end
            total++; if (frame_start !== (t == 64)) begin bad++; $display("FAIL scan_fs t=%0d got=%b", t, frame_start); end
        end
    endtask

    task automatic test_shadow();
        logic [6:0] cur_seg [4];
        logic [6:0] nxt_seg [4];
        int slot;
        cur_seg[0] = S4; cur_seg[1] = S3; cur_seg[2] = S2; cur_seg[3] = S1;
        nxt_seg[0] = S8; nxt_seg[1] = S7; nxt_seg[2] = S6; nxt_seg[3] = S5;
        for (int t = 1; t <= 64; t++) begin
            tick();
            slot = (t - 1) / 16;
            total++; if (seg !== cur_seg[slot]) begin bad++; $display("FAIL shadow_hold t=%0d got=%b exp=%b", t, seg, cur_seg[slot]); end
            if (t == 10) begin digits_in = 16'h4321; load = 1'b1; end
            if (t == 40) begin digits_in = 16'h5678; load = 1'b1; end
            if (t == 11 || t == 41) load = 1'b0;
        end
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL shadow_fs got=%b exp=1", frame_start); end
        for (int t = 1; t <= 64; t++) begin
            tick();
            slot = (t - 1) / 16;
            total++; if (seg !== nxt_seg[slot]) begin bad++; $display("FAIL shadow_last t=%0d got=%b exp=%b", t, seg, nxt_seg[slot]); end
        end
    endtask

    task automatic test_blank();
        logic [6:0] e1 [4];
        logic [6:0] e2 [4];
        logic       d1 [4];
        int slot;
        e1[0] = S0; e1[1] = S7; e1[2] = SBLK; e1[3] = SBLK;
        e2[0] = S0; e2[1] = SBLK; e2[2] = SBLK; e2[3] = SBLK;
        d1[0] = 1'b1; d1[1] = 1'b1; d1[2] = 1'b0; d1[3] = 1'b1;
        blank_lz = 1'b1;
        do_load(16'h0070, 4'b0100);
        wait_frame();
        for (int t = 1; t <= 64; t++) begin
            tick();
            slot = (t - 1) / 16;
            if ((t % 16) == 1) begin
                total++; if (seg !== e1[slot]) begin bad++; $display("FAIL blank_seg slot=%0d got=%b exp=%b", slot, seg, e1[slot]); end
                total++; if (dp !== d1[slot]) begin bad++; $display("FAIL blank_dp slot=%0d got=%b exp=%b", slot, dp, d1[slot]); end
            end
        end
        do_load(16'h0000, 4'b0000);
        wait_frame();
        for (int t = 1; t <= 64; t++) begin
            tick();
            slot = (t - 1) / 16;
            if ((t % 16) == 1) begin
                total++; if (seg !== e2[slot]) begin bad++; $display("FAIL blank_zero slot=%0d got=%b exp=%b", slot, seg, e2[slot]); end
                total++; if (dp !== 1'b1) begin bad++; $display("FAIL blank_zero_dp slot=%0d got=%b exp=1", slot, dp); end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_hex();
        logic [6:0] eh [4];
        int slot;
        eh[0] = SD; eh[1] = SC; eh[2] = SB; eh[3] = SA;
        hex_mode = 1'b1;
        repeat (63) tick();
        // This load is sampled on the frame boundary itself.
        do_load(16'hABCD, 4'b0000);
        total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL hex_boundary_fs got=%b exp=1", frame_start); end
        for (int t = 1; t <= 64; t++) begin
            tick();
            slot = (t - 1) / 16;
            if ((t % 16) == 1) begin
                total++; if (seg !== eh[slot]) begin bad++; $display("FAIL hex_seg slot=%0d got=%b exp=%b", slot, seg, eh[slot]); end
            end
        end
        hex_mode = 1'b0;
        for (int t = 1; t <= 64; t++) begin
            tick();
            if ((t % 16) == 1) begin
                total++; if (seg !== SDASH) begin bad++; $display("FAIL dec_dash t=%0d got=%b exp=%b", t, seg, SDASH); end
            end
        end
    endtask

    task automatic test_pwm();
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        int slot;
        int on_cnt;
        brightness = 2'd1;
        on_cnt = 0;
        for (int t = 1; t <= 64; t++) begin
            tick();
            slot = (t - 1) / 16;
            if (((t - 1) % 16) < 4) begin
                exp_an  = ~(4'b0001 << slot);
                exp_seg = SDASH;
            end else begin
                exp_an  = 4'b1111;
                exp_seg = SBLK;
            end
            if (an !== 4'b1111) on_cnt++;
            total++; if (an !== exp_an) begin bad++; $display("FAIL pwm1_an t=%0d got=%b exp=%b", t, an, exp_an); end
            total++; if (seg !== exp_seg) begin bad++; $display("FAIL pwm1_seg t=%0d got=%b exp=%b", t, seg, exp_seg); end
        end
        total++; if (on_cnt != 16) begin bad++; $display("FAIL pwm1_on_count got=%0d exp=16", on_cnt); end
        brightness = 2'd0;
        for (int t = 1; t <= 64; t++) begin
            tick();
            total++; if (an !== 4'b1111 || dp !== 1'b1) begin bad++; $display("FAIL pwm0_dark t=%0d an=%b dp=%b exp an=1111 dp=1", t, an, dp); end
        end
        brightness = 2'd3;
    endtask

    task automatic test_reset_pending();
        int slot;
        do_load(16'h1111, 4'b1111);
        repeat (5) tick();
        rst = 1'b0;
        repeat (2) tick();
        total++; if (an !== 4'b1111 || seg !== SBLK) begin bad++; $display("FAIL rstp_idle an=%b seg=%b exp an=1111 seg=%b", an, seg, SBLK); end
        rst = 1'b1;
        tick();
        total++; if (an !== 4'b1110 || seg !== S0) begin bad++; $display("FAIL rstp_release an=%b seg=%b exp an=1110 seg=%b", an, seg, S0); end
        wait_frame();
        for (int t = 1; t <= 64; t++) begin
            tick();
            slot = (t - 1) / 16;
            if ((t % 16) == 1) begin
                total++; if (seg !== S0 || dp !== 1'b1) begin bad++; $display("FAIL rstp_dropped slot=%0d seg=%b dp=%b exp seg=%b dp=1", slot, seg, dp, S0); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_shadow();
        test_blank();
        test_hex();
        test_pwm();
        test_reset_pending();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
